kernel_line_buffer: RTL

//  Parametrised N-row line buffer. Feeds KERNEL_SIZE vertically adjacent pixels per column to

---
 rtl/kernel_line_buffer_pkg.sv | 29 ++
 rtl/kernel_line_buffer_ram.sv | 69 ++++++
 rtl/kernel_line_buffer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/kernel_line_buffer_pkg.sv
// -----------------------------------------------------------------------------
// kernel_line_buffer_pkg
// Shared constants and helpers for the kernel line buffer.
//   HCOUNT_W / VCOUNT_W : widths of the column / line counters on the video bus
//   row_idx()           : maps an output row slot k to the physical row RAM,
//                         given the write-select that was active for the pixel
//   vwrap()             : subtracts an offset from a line number, modulo VRES
// -----------------------------------------------------------------------------
package kernel_line_buffer_pkg;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

    // The RAM after the one being written holds the oldest stored line, so
    // slot k (0 = oldest) lives k+1 RAMs past the write-select.
    function automatic int row_idx(input int ws, input int k, input int kernel);
        return (ws + 1 + k) % (kernel + 1);
    endfunction

    // Line number 'off' lines before v, wrapping into the previous frame.
    function automatic logic [VCOUNT_W-1:0] vwrap(input logic [VCOUNT_W-1:0] v,
                                                  input int off,
                                                  input int vres);
        int t;
        t = (int'(v) + vres - off) % vres;
        return VCOUNT_W'(t);
    endfunction

endpackage

// File: rtl/kernel_line_buffer_ram.sv
// -----------------------------------------------------------------------------
// xilinx_true_dual_port_read_first_1_clock_ram
// Single-clock dual-port block RAM, read-first. Port A writes, port B reads.
// With RAM_PERFORMANCE = "HIGH_PERFORMANCE" the read path carries an extra
// output register, giving two cycles from addrb to doutb; "LOW_LATENCY" gives
// one cycle.
// Ports:
//   clka    in   clock shared by both ports
//   addra   in   write address
//   dina    in   write data
//   wea     in   write enable
//   ena     in   port A enable
//   addrb   in   read address
//   enb     in   port B enable
//   rstb    in   synchronous clear of the port B output register
//   regceb  in   port B output register clock enable
//   doutb   out  read data
// -----------------------------------------------------------------------------
module xilinx_true_dual_port_read_first_1_clock_ram #(
    parameter int RAM_WIDTH       = 16,
    parameter int RAM_DEPTH       = 1280,
    parameter int ADDR_W          = $clog2(RAM_DEPTH),
    parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic                 clka,
    input  logic [ADDR_W-1:0]    addra,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic                 wea,
    input  logic                 ena,
    input  logic [ADDR_W-1:0]    addrb,
    input  logic                 enb,
    input  logic                 rstb,
    input  logic                 regceb,
    output logic [RAM_WIDTH-1:0] doutb
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data_b;

    always_ff @(posedge clka) begin
        if (ena && wea) begin
            mem[addra] <= dina;
        end
    end

    // Read-first: a same-address write on port A is not visible on this read.
    always_ff @(posedge clka) begin
        if (enb) begin
            ram_data_b <= mem[addrb];
        end
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
            assign doutb = ram_data_b;
        end else begin : g_high_performance
            logic [RAM_WIDTH-1:0] doutb_reg;
            always_ff @(posedge clka) begin
                if (rstb) begin
                    doutb_reg <= '0;
                end else if (regceb) begin
                    doutb_reg <= ram_data_b;
                end
            end
            assign doutb = doutb_reg;
        end
    endgenerate

endmodule

// File: rtl/kernel_line_buffer.sv
// -----------------------------------------------------------------------------
// kernel_line_buffer
// N-row line buffer for a streaming video path. For every incoming pixel it
// presents KERNEL_SIZE vertically adjacent pixels from the same column, two
// cycles later, for downstream convolution / morphology stages.
// KERNEL_SIZE+1 row RAMs rotate: one row receives the current line while the
// other KERNEL_SIZE rows supply the previous lines.
//
// Optional feature (macro KERNEL_LINE_BUFFER_FILL_GATE_EN):
//   defined   - data_valid_out is held low until KERNEL_SIZE complete lines of
//               the current frame are stored, so lines wrapped in from the
//               previous frame are never presented as valid.
//   undefined - data_valid_out follows data_valid_in delayed by two cycles.
//
// Ports:
//   clk_in           in   system clock
//   rst_in           in   synchronous active-high reset
//   hcount_in        in   column of the incoming pixel
//   vcount_in        in   line of the incoming pixel
//   pixel_data_in    in   incoming pixel
//   data_valid_in    in   pixel qualifier
//   line_buffer_out  out  KERNEL_SIZE pixels of one column, [0] = oldest line
//   hcount_out       out  column of line_buffer_out
//   vcount_out       out  line of the centre row of line_buffer_out
//   data_valid_out   out  output qualifier
// -----------------------------------------------------------------------------
module kernel_line_buffer
    import kernel_line_buffer_pkg::*;
#(
    parameter int PIXEL_WIDTH = 16,
    parameter int HRES        = 1280,
    parameter int VRES        = 720,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                                    clk_in,
    input  logic                                    rst_in,
    input  logic [HCOUNT_W-1:0]                     hcount_in,
    input  logic [VCOUNT_W-1:0]                     vcount_in,
    input  logic [PIXEL_WIDTH-1:0]                  pixel_data_in,
    input  logic                                    data_valid_in,
    output logic [KERNEL_SIZE-1:0][PIXEL_WIDTH-1:0] line_buffer_out,
    output logic [HCOUNT_W-1:0]                     hcount_out,
    output logic [VCOUNT_W-1:0]                     vcount_out,
    output logic                                    data_valid_out
);

    localparam int NUM_ROWS = KERNEL_SIZE + 1;
    localparam int WS_W     = $clog2(NUM_ROWS);
    localparam int ADDR_W   = (HRES > 1) ? $clog2(HRES) : 1;
    // Centre row of the output window sits this many lines behind the input.
    localparam int V_OFF    = (KERNEL_SIZE + 1) / 2;

    logic [WS_W-1:0]        write_sel;
    logic                   line_end;
    logic [ADDR_W-1:0]      ram_addr;
    logic [PIXEL_WIDTH-1:0] row_dout [NUM_ROWS];

    logic                   vld_p1, vld_p2;
    logic [HCOUNT_W-1:0]    hcount_p1;
    logic [VCOUNT_W-1:0]    vcount_p1;
    logic [WS_W-1:0]        ws_p1, ws_p2;

    assign line_end = data_valid_in && (hcount_in == HCOUNT_W'(HRES - 1));
    assign ram_addr = hcount_in[ADDR_W-1:0];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            write_sel <= '0;
        end else if (line_end) begin
            write_sel <= (write_sel == WS_W'(KERNEL_SIZE)) ? '0 : write_sel + 1'b1;
        end
    end

    // ---- stage 0 -> 2: row RAMs (write current line, read all rows) ----
    generate
        for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
            xilinx_true_dual_port_read_first_1_clock_ram #(
                .RAM_WIDTH       (PIXEL_WIDTH),
                .RAM_DEPTH       (HRES),
                .ADDR_W          (ADDR_W),
                .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
            ) u_ram (
                .clka   (clk_in),
                .addra  (ram_addr),
                .dina   (pixel_data_in),
                .wea    (data_valid_in && (write_sel == WS_W'(i))),
                .ena    (1'b1),
                .addrb  (ram_addr),
                .enb    (1'b1),
                .rstb   (1'b0),
                .regceb (1'b1),
                .doutb  (row_dout[i])
            );
        end
    endgenerate

    // ---- stage 0 -> 1 -> 2: control pipeline matching the RAM latency ----
    // write_sel travels with the pixel so the last two pixels of a line are
    // still routed with the row assignment that was live when they entered.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            hcount_p1  <= '0;
            hcount_out <= '0;
            vcount_p1  <= '0;
            vcount_out <= '0;
            ws_p1      <= '0;
            ws_p2      <= '0;
        end else begin
            vld_p1     <= data_valid_in;
            vld_p2     <= vld_p1;
            hcount_p1  <= hcount_in;
            hcount_out <= hcount_p1;
            vcount_p1  <= vwrap(vcount_in, V_OFF, VRES);
            vcount_out <= vcount_p1;
            ws_p1      <= write_sel;
            ws_p2      <= ws_p1;
        end
    end

    // ---- stage 2: row mux ----
    always_comb begin
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            line_buffer_out[k] = row_dout[WS_W'(row_idx(int'(ws_p2), k, KERNEL_SIZE))];
        end
    end

`ifdef KERNEL_LINE_BUFFER_FILL_GATE_EN
    logic [WS_W-1:0] fill_cnt;
    logic [WS_W-1:0] fill_now;
    logic [WS_W-1:0] fill_p1, fill_p2;
    logic            frame_start;

    assign frame_start = data_valid_in && (hcount_in == '0) && (vcount_in == '0);
    // The first pixel of a frame must already see the cleared count, otherwise
    // it would inherit the saturated count of the previous frame.
    assign fill_now    = frame_start ? '0 : fill_cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fill_cnt <= '0;
            fill_p1  <= '0;
            fill_p2  <= '0;
        end else begin
            if (frame_start) begin
                fill_cnt <= '0;
            end else if (line_end && (fill_cnt != WS_W'(KERNEL_SIZE))) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            fill_p1 <= fill_now;
            fill_p2 <= fill_p1;
        end
    end

    assign data_valid_out = vld_p2 && (fill_p2 == WS_W'(KERNEL_SIZE));
`else
    assign data_valid_out = vld_p2;
`endif

endmodule
